div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Multi-cycle radix-2 restoring divider in EX; requester side of pipeline stall handshake.
//  Drives stallreq_o (feeds stall_ctrl stallreq_from_ex) while a DIV/DIVU is in flight.
//  Holds EX..IF until {HI,LO} result ready; supports annul on pipeline flush.
// PARAMETERS
//  DATA_W   32   operand width; result is 2*DATA_W {remainder,quotient}
//  CNT_W    6    iteration counter width; must hold DATA_W
// PORTS
//  clk           in   1         pipeline clock, rising edge
//  rst_n         in   1         async reset, active-low (`RstEnable = 1'b0)
//  start_i       in   1         EX holds a DIV/DIVU; sampled only in IDLE
//  signed_i      in   1         1=DIV (two's complement), 0=DIVU; latched at start
//  opdata1_i     in   DATA_W    dividend; latched at start
//  opdata2_i     in   DATA_W    divisor; latched at start
//  annul_i       in   1         flush/exception: abort op in flight
//  result_o      out  2*DATA_W  {rem[63:32]->HI, quo[31:0]->LO}, registered
//  ready_o       out  1         result valid; high exactly 1 cycle per op
//  stallreq_o    out  1         stall request, `Stop level when asserted
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, cnt=0, result_o=0, ready_o=0; stallreq_o=0.
//  States: IDLE, BYZERO, ON, END (encodings in defines.v).
//  IDLE: start_i & ~annul_i -> latch |op1|,|op2|, signs, signed_i; divisor==0 ? BYZERO : ON, cnt=0.
//  ON: 1 iteration/cycle: partial={rem,q_msb} - divisor; if no borrow keep and shift 1 into q,
//      else restore, shift 0. cnt++; after DATA_W iterations -> END, result_o written.
//  BYZERO: -> END, result_o=0.
//  END: ready_o=1; -> IDLE unconditionally; start_i ignored this cycle.
//  Sign fix (signed_i=1 only): quo negated if op signs differ; rem takes dividend sign.
//  Magnitudes computed in DATA_W unsigned; INT_MIN/-1 -> quo=0x80000000, rem=0 (wraps, no trap).
//  stallreq_o = start_i & ~annul_i & (state!=END); combinational from start_i.
//  Timing: cycle 0 = IDLE with start_i=1; ON cycles 1..32; END/ready_o in cycle 33;
//      stallreq_o high cycles 0..32, low cycle 33 so pipeline advances at end of cycle 33.
//  Upstream rule: EX captures result_o in ready_o cycle and drops start_i next cycle.
//  annul_i in ON/BYZERO: next state IDLE, ready_o never pulses, result_o unchanged.
//  annul_i in END: ignored (result already committed); annul_i in IDLE blocks start.
//  annul_i and start_i both high in IDLE: no op started.
//  Reset mid-op: immediate return to IDLE, outputs to reset values.
//  result_o holds last value between ops.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: divisor==0 -> BYZERO, ready_o in cycle 2, result_o=0.
//  Not defined: divisor==0 runs full ON path (ready_o cycle 33); result_o forced to 0 at END.
//  Result identical either way; only latency differs.
// STRUCTURE
//  defines.v: state encodings (DivFree/DivByZero/DivOn/DivEnd), `RstEnable, `Stop,
//      `NoStop, `DivResultReady/`DivResultNotReady.
//  Optional sub-module div_step: one combinational restoring subtract/shift step
//      (DATA_W+1 bit compare); FSM, counter, sign fix stay in div_seq.
// TESTING
//  DIVU 100/7, start held -> stallreq_o cycles 0..32, ready_o cycle 33, result_o={32'd2,32'd14}.
//  DIV -7/2 -> result_o={32'hFFFFFFFF,32'hFFFFFFFD}; DIV 7/-2 -> {32'h1,32'hFFFFFFFD}.
//  DIV 0x80000000/0xFFFFFFFF -> {32'h0,32'h80000000}, no hang.
//  Divisor 0: with DIV_ZERO_FAST_EN ready_o cycle 2, else cycle 33; result_o=0 both.
//  annul_i at cycle 10 -> stallreq_o 0 same cycle, IDLE next, no ready_o, result_o unchanged.
//  rst_n low at cycle 15, new DIVU 9/3 after release -> {0,3} at cycle 33 of new op; back-to-back ops.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential divider.
// State encodings and handshake levels used by div_seq and div_step.
package div_seq_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic RST_ENABLE           = 1'b0;
    localparam logic STOP                 = 1'b1;
    localparam logic NO_STOP              = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_seq_if.sv
// EX-side request/result bundle of the sequential divider.
// master = EX stage issuing the op, slave = divider.
interface div_seq_if #(
    parameter int DATA_W = 32
);

    logic                  start_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stallreq_o
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift quotient bit in.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] dvd_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] dvd_o
);

    logic [DATA_W:0] part;
    logic            fits;

    // The dividend register doubles as the quotient shift register.
    always_comb begin
        part  = {rem_i, dvd_i[DATA_W-1]};
        fits  = (part >= {1'b0, dvs_i});
        rem_o = fits ? (part[DATA_W-1:0] - dvs_i) : part[DATA_W-1:0];
        dvd_o = {dvd_i[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider with pipeline stall request.
// Optional DIV_ZERO_FAST_EN: zero divisor short-cuts through BYZERO.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    div_seq_if.slave  bus
);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvd_q, dvd_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                zero_q, zero_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   dvd_nxt;
    logic                go;
    logic                last;
    logic                zero_in;
    logic                neg1;
    logic                neg2;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign go      = bus.start_i & ~bus.annul_i;
    assign last    = (cnt_q == CNT_W'(DATA_W - 1));
    assign zero_in = (bus.opdata2_i == '0);
    assign neg1    = bus.signed_i & bus.opdata1_i[DATA_W-1];
    assign neg2    = bus.signed_i & bus.opdata2_i[DATA_W-1];

    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nxt),
        .dvd_o (dvd_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ENABLE) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_FREE: begin
                if (go) begin
`ifdef DIV_ZERO_FAST_EN
                    state_d = zero_in ? DIV_BYZERO : DIV_ON;
`else
                    state_d = DIV_ON;
`endif
                end
            end
            DIV_BYZERO: state_d = bus.annul_i ? DIV_FREE : DIV_END;
            DIV_ON: begin
                if (bus.annul_i)
                    state_d = DIV_FREE;
                else if (last)
                    state_d = DIV_END;
            end
            DIV_END: state_d = DIV_FREE;
            default: state_d = DIV_FREE;
        endcase
    end

    // Sign fix: quotient negative when signs differ, remainder follows dividend.
    assign quo_fix = neg_quo_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
    assign rem_fix = neg_rem_q ? (~rem_nxt + 1'b1) : rem_nxt;

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zero_d    = zero_q;
        result_d  = result_q;
        unique case (state_q)
            DIV_FREE: begin
                if (go) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    dvd_d     = neg1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
                    dvs_d     = neg2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
                    neg_quo_d = neg1 ^ neg2;
                    neg_rem_d = neg1;
                    zero_d    = zero_in;
                end
            end
            DIV_BYZERO: begin
                if (!bus.annul_i)
                    result_d = '0;
            end
            DIV_ON: begin
                if (!bus.annul_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rem_d = rem_nxt;
                    dvd_d = dvd_nxt;
                    if (last)
                        result_d = zero_q ? '0 : {rem_fix, quo_fix};
                end
            end
            DIV_END: ;
            default: ;
        endcase
    end

    assign bus.result_o   = result_q;
    assign bus.ready_o    = (state_q == DIV_END) ? DIV_RESULT_READY
                                                 : DIV_RESULT_NOT_READY;
    assign bus.stallreq_o = (go && state_q != DIV_END) ? STOP : NO_STOP;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: vector table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_div_seq;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 2;
`else
    localparam int ZLAT = 33;
`endif
    localparam int LAT = 33;

    logic clk;
    logic rst_n;

    div_seq_if #(.DATA_W(32)) bus ();

    div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input bit s);
        longint q;
        longint r;
        if (b == 0) return 64'd0;
        if (s) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
        end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit s, output logic [63:0] res,
                          output int lat);
        bit stall_ok;
        stall_ok = 1'b1;
        lat = -1;
        res = 'x;
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.ready_o) begin
                lat = c;
                res = bus.result_o;
                if (bus.stallreq_o) stall_ok = 1'b0;
                break;
            end
            if (!bus.stallreq_o) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("ready_pulse_width", {63'd0, bus.ready_o}, 64'd0);
        chk("stallreq_profile", {63'd0, stall_ok}, 64'd1);
    endtask

    logic [63:0] res;
    logic [63:0] last_res;
    int          lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'd100,        32'd7,          1'b0, 64'h00000002_0000000E};
        tbl[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD};
        tbl[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 64'h00000001_FFFFFFFD};
        tbl[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 64'h00000000_80000000};
        tbl[4]  = '{32'd9,          32'd3,          1'b0, 64'h00000000_00000003};
        tbl[5]  = '{32'd1234,       32'd0,          1'b0, 64'h0};
        tbl[6]  = '{32'h80000000,   32'd0,          1'b1, 64'h0};
        tbl[7]  = '{32'd0,          32'd5,          1'b1, 64'h0};
        tbl[8]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 64'h00000000_FFFFFFFF};
        tbl[9]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1, 64'h00000000_00000001};
        tbl[10] = '{32'hFFFFFFFF,   32'd16,         1'b0, 64'h0000000F_0FFFFFFF};
        tbl[11] = '{32'h80000000,   32'd3,          1'b1, 64'hFFFFFFFE_D5555556};

        rst_n         = 1'b0;
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.annul_i   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_result", bus.result_o, 64'd0);
        chk("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        chk("reset_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vector table; ops run back to back.
        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, res, lat);
            chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
            chk($sformatf("tbl%0d_latency", i), 64'(lat),
                64'(tbl[i].b == 0 ? ZLAT : LAT));
        end

        run_op(32'd100, 32'd7, 1'b0, last_res, lat);

        // Annul while ON at cycle 10.
        begin
            bit no_ready;
            no_ready = 1'b1;
            @(posedge clk); #1;
            bus.start_i   = 1'b1;
            bus.signed_i  = 1'b0;
            bus.opdata1_i = 32'd5000;
            bus.opdata2_i = 32'd3;
            repeat (10) @(posedge clk);
            #1 bus.annul_i = 1'b1;
            @(negedge clk);
            chk("annul_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            bus.annul_i = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.ready_o) no_ready = 1'b0;
            end
            chk("annul_no_ready", {63'd0, no_ready}, 64'd1);
            chk("annul_result_hold", bus.result_o, last_res);
        end

        // start and annul together in IDLE must not start an op.
        begin
            bit no_ready;
            no_ready = 1'b1;
            @(posedge clk); #1;
            bus.start_i   = 1'b1;
            bus.annul_i   = 1'b1;
            bus.opdata1_i = 32'd8;
            bus.opdata2_i = 32'd2;
            @(negedge clk);
            chk("idle_annul_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            bus.annul_i = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.ready_o) no_ready = 1'b0;
            end
            chk("idle_annul_no_op", {63'd0, no_ready}, 64'd1);
            chk("idle_annul_result", bus.result_o, last_res);
        end

        // Reset at cycle 15 of an op, then a fresh op.
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b1;
        bus.opdata1_i = 32'hFFFF0000;
        bus.opdata2_i = 32'd77;
        repeat (15) @(posedge clk);
        #1;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("midreset_result", bus.result_o, 64'd0);
        chk("midreset_ready", {63'd0, bus.ready_o}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(32'd9, 32'd3, 1'b0, res, lat);
        chk("after_reset_result", res, 64'h00000000_00000003);
        chk("after_reset_latency", 64'(lat), 64'(LAT));

        // Random ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          s;
            int          mode;
            a    = $urandom;
            s    = $urandom_range(0, 1);
            mode = $urandom_range(0, 6);
            if (mode == 0) b = 32'd0;
            else if (mode == 1) b = $urandom_range(1, 15);
            else if (mode == 2) b = -$urandom_range(1, 15);
            else b = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            if (mode == 6) b = 32'hFFFFFFFF;
            run_op(a, b, s, res, lat);
            chk($sformatf("rnd%0d_result a=%h b=%h s=%0d", i, a, b, s),
                res, ref_div(a, b, s));
            chk($sformatf("rnd%0d_latency", i), 64'(lat),
                64'(b == 0 ? ZLAT : LAT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
